mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction-fetch stage and the MEM stage. It serialises 32-bit accesses onto the byte-wide synchronous RAM port, with MEM-stage requests taking priority over fetch. It returns one-cycle `done` pulses that the pipeline stall logic uses to hold IF/ID and later stage registers. Branch flush can abandon an in-flight fetch.

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises 32-bit fetch and load/store accesses onto a byte-wide RAM; MEM requests outrank fetch.
// Latency from grant: read N+2, store N+1 cycles; requesters hold req while busy, done pulses one cycle.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] rbuf_nxt;
    logic        own_mem;
    logic        grant_mem;
    logic        grant_if;
    logic        busy;
    logic [1:0]  lane;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = 32'd0;
        ram_wdata = 8'd0;
        ram_we    = 1'b0;
        if_done   = 1'b0;
        mem_done  = 1'b0;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    grant_mem = 1'b1;
                    state_nxt = mem_write ? MEM_WR : MEM_RD;
                end else if (if_req && !if_flush) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (cnt < nbytes) begin
                    ram_addr = addr_q + {29'd0, cnt};
                end
                // A flush wins even on the final capture cycle of a fetch.
                if (state == IF_RD && if_flush) begin
                    state_nxt = IDLE;
                end else if (cnt == nbytes) begin
                    state_nxt = DONE;
                end
            end
            MEM_WR: begin
                ram_addr  = addr_q + {29'd0, cnt};
                ram_wdata = wdata_q[{cnt[1:0], 3'b000} +: 8];
                ram_we    = 1'b1;
                if (cnt == nbytes - 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_done   = !own_mem;
                mem_done  = own_mem;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == IF_RD) || (state == MEM_RD) || (state == MEM_WR);
    // ram_rdata lags the issued address by one cycle, so it lands in lane cnt-1.
    assign lane = cnt[1:0] - 2'd1;

    always_comb begin
        rbuf_nxt = rbuf;
        if (cnt != 3'd0) begin
            rbuf_nxt[{lane, 3'b000} +: 8] = ram_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= 3'd0;
            nbytes    <= 3'd4;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rbuf      <= 32'd0;
            own_mem   <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if (grant_mem) begin
                cnt     <= 3'd0;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                rbuf    <= 32'd0;
                own_mem <= 1'b1;
                case (mem_size)
                    2'd0:    nbytes <= 3'd1;
                    2'd1:    nbytes <= 3'd2;
                    default: nbytes <= 3'd4;
                endcase
            end else if (grant_if) begin
                cnt     <= 3'd0;
                addr_q  <= if_addr;
                wdata_q <= 32'd0;
                rbuf    <= 32'd0;
                own_mem <= 1'b0;
                nbytes  <= 3'd4;
            end else if (busy) begin
                cnt  <= cnt + 3'd1;
                rbuf <= rbuf_nxt;
            end
            // Result registers only change when a read actually completes.
            if (state == IF_RD && state_nxt == DONE) begin
                if_data <= rbuf_nxt;
            end
            if (state == MEM_RD && state_nxt == DONE) begin
                mem_rdata <= rbuf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: byte RAM model, reference memory, directed and random transactions.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    mem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 fetch, 1 load, 2 store
    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t expq[$];
    wr_t  wq[$];

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_if;
    logic [31:0] last_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] pred_rd(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            r[8*i +: 8] = ref_mem[ai[15:0]];
        end
        return r;
    endfunction

    task automatic pred_wr(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ai;
        wr_t w;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = wd[8*i +: 8];
            w.a = ai;
            w.d = wd[8*i +: 8];
            wq.push_back(w);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a[15:0]] <= d;
        ref_mem[a[15:0]] = d;
    endtask

    task automatic push_exp(input int kind, input logic [31:0] data, input int when);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = when;
        expq.push_back(e);
    endtask

    // Byte RAM with one-cycle read latency; every write must match the predicted write stream.
    always @(posedge clock) begin
        if (ram_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_write: addr 0x%08h data 0x%02h at cycle %0d", ram_addr, ram_wdata, cyc);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("ram_write_addr", ram_addr, w.a);
                chk("ram_write_data", {24'd0, ram_wdata}, {24'd0, w.d});
            end
            ram[ram_addr[15:0]] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr[15:0]];
    end

    // Completion monitor: pops the scoreboard on every done pulse and checks result hold.
    always @(negedge clock) begin
        if (reset) begin
            last_if  = 32'd0;
            last_mem = 32'd0;
        end else begin
            if (if_done && mem_done) begin
                checks++;
                errors++;
                $display("FAIL both_done: if_done and mem_done together at cycle %0d", cyc);
            end else if (if_done || mem_done) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: if_done %0b mem_done %0b at cycle %0d", if_done, mem_done, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_owner_mem", {31'd0, mem_done}, {31'd0, e.kind != 0});
                    chk("done_cycle", cyc, e.cyc);
                    if (e.kind == 0) begin
                        chk("if_data", if_data, e.data);
                        last_if = e.data;
                    end else if (e.kind == 1) begin
                        chk("mem_rdata", mem_rdata, e.data);
                        last_mem = e.data;
                    end
                end
            end
            chk("if_data_hold", if_data, last_if);
            chk("mem_rdata_hold", mem_rdata, last_mem);
        end
    end

    task automatic run_fetch(input logic [31:0] a, input bit solo, input int flush_at);
        int t0;
        int k;
        t0 = cyc;
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            k = cyc - t0;
            if (solo && k >= 1 && k <= 5) begin
                chk("fetch_ram_addr", ram_addr, (k <= 4) ? a + 32'(k - 1) : 32'd0);
                chk("fetch_ram_we", {31'd0, ram_we}, 32'd0);
            end
            if (k == flush_at) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
                @(negedge clock);
                if_flush = 1'b0;
                return;
            end
            if (if_done) begin
                if_req = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL fetch_timeout: no if_done for addr 0x%08h", a);
        if_req = 1'b0;
    endtask

    task automatic run_mem(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit solo);
        int t0;
        int k;
        int n;
        t0 = cyc;
        n  = nbytes_of(sz);
        mem_write = w;
        mem_size  = sz;
        mem_addr  = a;
        mem_wdata = wd;
        mem_req   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            k = cyc - t0;
            if (solo && k >= 1 && k <= n) begin
                chk("mem_ram_addr", ram_addr, a + 32'(k - 1));
                chk("mem_ram_we", {31'd0, ram_we}, {31'd0, w});
                if (w) chk("mem_ram_wdata", {24'd0, ram_wdata}, {24'd0, wd[8*(k-1) +: 8]});
            end
            if (solo && k == n + 1) begin
                chk("mem_ram_we_after", {31'd0, ram_we}, 32'd0);
                chk("mem_ram_addr_after", ram_addr, 32'd0);
            end
            if (mem_done) begin
                mem_req = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL mem_timeout: no mem_done for addr 0x%08h", a);
        mem_req = 1'b0;
    endtask

    // mode: 0 fetch, 1 load/store, 2 both together, 3 fetch flushed at cycle t0+flush_at
    task automatic do_scn(input int mode, input logic [31:0] fa, input logic w, input logic [1:0] sz,
                          input logic [31:0] ma, input logic [31:0] wd, input int flush_at);
        int t0;
        int n;
        int lm;
        t0 = cyc;
        n  = nbytes_of(sz);
        lm = w ? n + 1 : n + 2;
        if (mode == 1 || mode == 2) begin
            if (w) begin
                pred_wr(ma, n, wd);
                push_exp(2, 32'd0, t0 + lm);
            end else begin
                push_exp(1, pred_rd(ma, n), t0 + lm);
            end
        end
        if (mode == 0) push_exp(0, pred_rd(fa, 4), t0 + 6);
        if (mode == 2) push_exp(0, pred_rd(fa, 4), t0 + lm + 7);
        case (mode)
            0: run_fetch(fa, 1'b1, -1);
            1: run_mem(w, sz, ma, wd, 1'b1);
            2: fork
                   run_mem(w, sz, ma, wd, 1'b0);
                   run_fetch(fa, 1'b0, -1);
               join
            default: run_fetch(fa, 1'b1, flush_at);
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int mode;
        int t0;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clock);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Word fetch at 0x100
        poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        @(negedge clock);
        do_scn(0, 32'h100, 1'b0, 2'd0, 32'd0, 32'd0, -1);
        @(negedge clock);

        // Simultaneous load word and fetch
        poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
        @(negedge clock);
        do_scn(2, 32'h100, 1'b0, 2'd2, 32'h200, 32'd0, -1);
        @(negedge clock);

        // Half store then byte load
        do_scn(1, 32'd0, 1'b1, 2'd1, 32'h301, 32'h0000A1B2, -1);
        @(negedge clock);
        do_scn(1, 32'd0, 1'b0, 2'd0, 32'h302, 32'd0, -1);
        @(negedge clock);

        // Flush in the third IF_RD cycle, then a fetch that completes
        do_scn(3, 32'h500, 1'b0, 2'd0, 32'd0, 32'd0, 3);
        do_scn(0, 32'h504, 1'b0, 2'd0, 32'd0, 32'd0, -1);
        @(negedge clock);

        // Back-to-back fetches at the minimum period
        do_scn(0, 32'h600, 1'b0, 2'd0, 32'd0, 32'd0, -1);
        @(negedge clock);
        do_scn(0, 32'h604, 1'b0, 2'd0, 32'd0, 32'd0, -1);
        @(negedge clock);

        // Reset in the middle of a word store
        t0 = cyc;
        mem_write = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h400;
        mem_wdata = 32'h11223344;
        mem_req   = 1'b1;
        pred_wr(32'h400, 2, 32'h11223344);
        @(negedge clock);
        chk("rstmid_we_active", {31'd0, ram_we}, 32'd1);
        @(negedge clock);
        reset   = 1'b1;
        mem_req = 1'b0;
        @(negedge clock);
        chk("rstmid_cycle", cyc - t0, 32'd3);
        chk("rstmid_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rstmid_ram_addr", ram_addr, 32'd0);
        chk("rstmid_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rstmid_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rstmid_if_done", {31'd0, if_done}, 32'd0);
        chk("rstmid_if_data", if_data, 32'd0);
        chk("rstmid_mem_rdata", mem_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Address wrap
        do_scn(0, 32'hFFFFFFFE, 1'b0, 2'd0, 32'd0, 32'd0, -1);
        @(negedge clock);

        for (int it = 0; it < 160; it++) begin
            mode = $urandom_range(0, 3);
            do_scn(mode, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom_range(1, 5));
            repeat ((mode == 3) ? $urandom_range(0, 2) : $urandom_range(1, 3)) @(negedge clock);
        end

        repeat (10) @(negedge clock);
        chk("expq_drained", expq.size(), 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
